rot_ascii_encoder: RTL and testbench
====================================

Name: rot_ascii_encoder

Overview:
- Producer side of the rotation-word interface: parses a raw ASCII puzzle byte stream (lines such as "R26\n" and "L5\n") into packed rotation words.
- The dial solver then consumes these words. This removes the offline conversion step.
- Sits between the byte source (file/UART loader) and the solver's word input or its input memory.
- One byte per cycle on input; one packed word per line on output, both with valid/ready.

Parameters:
- MAG_W, 10, magnitude width in bits. Output word width is MAG_W+1.
- CNT_W, 13, width of the emitted-word counter. 13 bits covers 4126 lines.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- in_data  in  8  ASCII byte
- in_last  in  1  marks final byte of the stream; qualified by the handshake
- out_valid  out  1  packed word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  MAG_W+1  [MAG_W] = direction (1 = L, 0 = R); [MAG_W-1:0] = unsigned binary magnitude
- word_count  out  CNT_W  words accepted downstream (out_valid && out_ready)
- done  out  1  sticky; stream ended cleanly
- err  out  1  sticky; parse error
- err_code  out  2  01 bad char, 10 magnitude overflow, 11 missing digits/truncated; 00 when !err

Behaviour:
- Reset (sync, rst high at a clk edge):
  - state = EXP_DIR; accumulator = 0.
  - out_valid = 0, out_data = 0, word_count = 0, done = 0, err = 0, err_code = 00, in_ready = 1 on the next cycle.
  - A partially parsed line is discarded. rst has priority over every other event.
- FSM states: EXP_DIR, EXP_DIG1, DIGITS, EMIT, DONE, ERROR.
- EXP_DIR:
  - 'R' or 'L': latch dir, clear acc, go to EXP_DIG1.
  - '\n': blank line, ignored, stay.
  - Any other byte: ERROR, code 01.
  - in_last with 'R' or 'L': ERROR, code 11.
  - in_last with '\n': DONE.
- EXP_DIG1:
  - '0'..'9': acc = digit, go to DIGITS.
  - '\n': ERROR, code 11.
  - Any other byte: ERROR, code 01.
  - in_last with a digit: go to EMIT with pending-last flag set.
- DIGITS:
  - Digit: acc_next = acc*10 + digit, computed at MAG_W+4 bits. If acc_next > 2^MAG_W-1: ERROR, code 10. Otherwise acc = acc_next.
  - '\n': go to EMIT.
  - Any other byte: ERROR, code 01.
  - in_last on '\n' or on a digit (no trailing newline): go to EMIT with pending-last flag set.
  - Leading zeros are legal.
- EMIT:
  - out_valid = 1; out_data = {dir, acc[MAG_W-1:0]}, held stable until accepted.
  - in_ready = 0.
  - On out_valid && out_ready: word_count++ and out_valid drops next cycle. Next state is DONE if the pending-last flag is set, else EXP_DIR.
  - Cost: one input bubble per line. This is accepted.
- in_ready = 1 in EXP_DIR, EXP_DIG1, DIGITS, DONE, ERROR; 0 only in EMIT.
- DONE:
  - done = 1; further bytes are accepted and dropped.
  - out_valid stays 0 until reset.
- ERROR:
  - err = 1, err_code is latched from the first error.
  - Input keeps draining (in_ready = 1, bytes dropped) so upstream never hangs.
  - No further words; done stays 0.
- word_count wraps modulo 2^CNT_W; no saturation.
- out_valid must never drop without an accept. out_data must not change while out_valid && !out_ready.

Optional Feature:
- Macro ROT_ENC_CRLF_EN.
- Defined:
  - A '\r' in DIGITS moves to a CR_SEEN sub-state. In CR_SEEN, '\n' behaves as the terminator and any other byte gives code 01.
  - A '\r' in EXP_DIR (CRLF blank line) is ignored.
  - in_last on '\r' is treated as the terminator.
- Undefined: '\r' anywhere gives ERROR, code 01.

Decomposition:
- Package rot_enc_pkg holds:
  - ASCII constants: CH_R, CH_L, CH_NL, CH_CR, CH_0, CH_9.
  - State enum typedef.
  - Error-code localparams: ERR_NONE, ERR_BADCH, ERR_OVF, ERR_TRUNC.
  - Direction encoding: DIR_R = 0, DIR_L = 1.
- One sub-module, rot_dec_accum:
  - Inputs: acc, digit. Outputs: acc*10 + digit, ovf flag.
  - Combinational; parameterised by MAG_W.

Test Plan:
- "R26\nL5\n", last on final '\n', out_ready = 1 → words 0x01A then 0x405; word_count = 2; done = 1; err = 0.
- "L0007\nR1023" with no trailing newline, out_ready low 3 cycles on each word → 0x407, 0x3FF. out_data is stable while stalled, in_ready = 0 during EMIT, done = 1.
- "R1024\n" → no word; err = 1, err_code = 10. A following byte is still accepted (in_ready = 1).
- "R\n" → err_code = 11. "X5\n" → err_code = 01. Separately, "\n\nR3\n" → single word 0x003.
- rst asserted mid-line after "L12" → all outputs cleared next cycle. A subsequent "R1\n" yields 0x001, word_count = 1.
- "R4\r\n":
  - With ROT_ENC_CRLF_EN → 0x004, no error.
  - Without ROT_ENC_CRLF_EN → err_code = 01.

Source files
------------

// File: rtl/rot_enc_pkg.sv
// rot_enc_pkg: shared constants and types for the ASCII rotation-word encoder.
// ASCII byte codes, parser state enum, error codes and direction encoding.
package rot_enc_pkg;

  // ASCII bytes the parser cares about
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_NL = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  // Sticky error codes; ERR_NONE whenever no error has been seen
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_BADCH = 2'b01;
  localparam logic [1:0] ERR_OVF   = 2'b10;
  localparam logic [1:0] ERR_TRUNC = 2'b11;

  // Direction bit in the packed word
  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  // Parser states; CR_SEEN is only reachable with CRLF support built in
  typedef enum logic [2:0] {
    EXP_DIR  = 3'd0,
    EXP_DIG1 = 3'd1,
    DIGITS   = 3'd2,
    EMIT     = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5,
    CR_SEEN  = 3'd6
  } rot_state_e;

  // True for '0'..'9'
  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/rot_dec_accum.sv
// rot_dec_accum: one decimal-accumulate step, acc*10 + digit.
// The product is formed MAG_W+4 bits wide so the overflow test is exact;
// sum carries the low MAG_W bits, only meaningful when ovf is clear.
module rot_dec_accum #(
  parameter int MAG_W = 10
) (
  input  logic [MAG_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [MAG_W-1:0] sum,
  output logic             ovf
);

  logic [MAG_W+3:0] acc_ext;
  logic [MAG_W+3:0] wide;

  // acc*10 as (acc<<3)+(acc<<1), then add the digit; any high bit set means > 2^MAG_W-1
  always_comb begin
    acc_ext = {4'b0000, acc};
    wide    = (acc_ext << 3) + (acc_ext << 1) + {{MAG_W{1'b0}}, digit};
    sum     = wide[MAG_W-1:0];
    ovf     = |wide[MAG_W+3:MAG_W];
  end

endmodule

// File: rtl/rot_ascii_encoder.sv
// rot_ascii_encoder: parses an ASCII stream of lines like "R26\n" / "L5\n"
// into packed words {dir, magnitude}, one byte in per cycle, one word out per line.
// Optional build macro: ROT_ENC_CRLF_EN (accept CRLF line endings).
module rot_ascii_encoder
  import rot_enc_pkg::*;
#(
  parameter int MAG_W = 10,
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W:0]   out_data,
  output logic [CNT_W-1:0] word_count,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  rot_state_e       state, state_nxt;
  logic             dir, dir_nxt;
  logic [MAG_W-1:0] acc, acc_nxt;
  logic             pend_last, pend_nxt;
  logic [1:0]       code_q, code_nxt;
  logic [CNT_W-1:0] wc_q, wc_nxt;

  logic [MAG_W-1:0] mac_sum;
  logic             mac_ovf;
  logic             byte_acc;
  logic             is_dig;

  rot_dec_accum #(.MAG_W(MAG_W)) u_accum (
    .acc   (acc),
    .digit (in_data[3:0]),
    .sum   (mac_sum),
    .ovf   (mac_ovf)
  );

  // State and datapath registers; reset discards any half-parsed line
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EXP_DIR;
      dir       <= DIR_R;
      acc       <= '0;
      pend_last <= 1'b0;
      code_q    <= ERR_NONE;
      wc_q      <= '0;
    end else begin
      state     <= state_nxt;
      dir       <= dir_nxt;
      acc       <= acc_nxt;
      pend_last <= pend_nxt;
      code_q    <= code_nxt;
      wc_q      <= wc_nxt;
    end
  end

  // Next-state and outputs; the word is a pure function of registered dir/acc so it holds while stalled
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    acc_nxt   = acc;
    pend_nxt  = pend_last;
    code_nxt  = code_q;
    wc_nxt    = wc_q;

    in_ready  = (state != EMIT);
    out_valid = (state == EMIT);
    out_data  = out_valid ? {dir, acc} : '0;
    done      = (state == DONE);
    err       = (state == ERROR);
    err_code  = code_q;

    byte_acc  = in_valid && in_ready;
    is_dig    = is_digit(in_data);

    case (state)
      EXP_DIR: if (byte_acc) begin
        if (in_data == CH_R || in_data == CH_L) begin
          if (in_last) begin
            state_nxt = ERROR;
            code_nxt  = ERR_TRUNC;
          end else begin
            dir_nxt   = (in_data == CH_L) ? DIR_L : DIR_R;
            acc_nxt   = '0;
            state_nxt = EXP_DIG1;
          end
        end else if (in_data == CH_NL) begin
          if (in_last) state_nxt = DONE;
`ifdef ROT_ENC_CRLF_EN
        end else if (in_data == CH_CR) begin
          // CR of a CRLF blank line; only ends the stream if it is the last byte
          if (in_last) state_nxt = DONE;
`endif
        end else begin
          state_nxt = ERROR;
          code_nxt  = ERR_BADCH;
        end
      end

      EXP_DIG1: if (byte_acc) begin
        if (is_dig) begin
          acc_nxt   = {{(MAG_W-4){1'b0}}, in_data[3:0]};
          pend_nxt  = in_last;
          state_nxt = in_last ? EMIT : DIGITS;
        end else if (in_data == CH_NL) begin
          state_nxt = ERROR;
          code_nxt  = ERR_TRUNC;
        end else begin
          state_nxt = ERROR;
          code_nxt  = ERR_BADCH;
        end
      end

      DIGITS: if (byte_acc) begin
        if (is_dig) begin
          if (mac_ovf) begin
            state_nxt = ERROR;
            code_nxt  = ERR_OVF;
          end else begin
            acc_nxt = mac_sum;
            if (in_last) begin
              pend_nxt  = 1'b1;
              state_nxt = EMIT;
            end
          end
        end else if (in_data == CH_NL) begin
          pend_nxt  = in_last;
          state_nxt = EMIT;
`ifdef ROT_ENC_CRLF_EN
        end else if (in_data == CH_CR) begin
          // A trailing CR on the final byte terminates the line by itself
          if (in_last) begin
            pend_nxt  = 1'b1;
            state_nxt = EMIT;
          end else begin
            state_nxt = CR_SEEN;
          end
`endif
        end else begin
          state_nxt = ERROR;
          code_nxt  = ERR_BADCH;
        end
      end

`ifdef ROT_ENC_CRLF_EN
      CR_SEEN: if (byte_acc) begin
        if (in_data == CH_NL) begin
          pend_nxt  = in_last;
          state_nxt = EMIT;
        end else begin
          state_nxt = ERROR;
          code_nxt  = ERR_BADCH;
        end
      end
`endif

      EMIT: if (out_ready) begin
        wc_nxt    = wc_q + 1'b1;
        state_nxt = pend_last ? DONE : EXP_DIR;
      end

      // DONE and ERROR drain input forever; nothing changes until reset
      DONE:    state_nxt = DONE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = state;
    endcase
  end

  assign word_count = wc_q;

endmodule

// File: tb/tb_rot_ascii_encoder.sv
// tb_rot_ascii_encoder: directed + random streams against a line-level reference model.
module tb_rot_ascii_encoder;
  localparam int MAG_W = 10;
  localparam int CNT_W = 13;
  localparam logic [7:0] B_NL = 8'h0A;
  localparam logic [7:0] B_R  = 8'h52;
  localparam logic [7:0] B_L  = 8'h4C;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [MAG_W:0]   out_data;
  logic [CNT_W-1:0] word_count;
  logic             done;
  logic             err;
  logic [1:0]       err_code;

  int checks = 0;
  int errors = 0;

  logic [MAG_W:0] got_words[$];
  logic [MAG_W:0] exp_words[$];
  logic           exp_done;
  logic           exp_err;
  logic [1:0]     exp_code;

  rot_ascii_encoder #(.MAG_W(MAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .word_count(word_count), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: split into lines, judge each line by the grammar, stop at the first error
  task automatic model(input string s);
    int n;
    int p;
    bit stop;
    n = s.len();
    p = 0;
    stop = 0;
    exp_words.delete();
    exp_err = 0;
    exp_code = 2'b00;
    exp_done = 0;
    while (p < n && !stop) begin
      int e;
      string ln;
      int val;
      e = p;
      while (e < n && s[e] != B_NL) e++;
      ln = (e > p) ? s.substr(p, e - 1) : "";
      p = e + 1;
      if (ln.len() == 0) continue;
      if (ln[0] != B_R && ln[0] != B_L) begin
        exp_err = 1; exp_code = 2'b01; stop = 1;
      end else if (ln.len() == 1) begin
        exp_err = 1; exp_code = 2'b11; stop = 1;
      end else begin
        val = 0;
        for (int k = 1; k < ln.len() && !stop; k++) begin
          if (ln[k] < 8'h30 || ln[k] > 8'h39) begin
            exp_err = 1; exp_code = 2'b01; stop = 1;
          end else begin
            val = val * 10 + int'(ln[k] - 8'h30);
            if (val > 1023) begin
              exp_err = 1; exp_code = 2'b10; stop = 1;
            end
          end
        end
        if (!stop) exp_words.push_back({(ln[0] == B_L), val[MAG_W-1:0]});
      end
    end
    if (!stop) exp_done = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive bytes (mode 0: random gaps/backpressure, 1: full rate, 2: out_ready low 3 cycles per word)
  task automatic run_stream(input string s, input int mode, input bit use_last);
    int idx;
    int n;
    int cyc;
    int stall;
    bit prev_hold;
    logic [MAG_W:0] prev_data;
    logic ov, ir, ord;
    logic [MAG_W:0] od;
    n = s.len();
    idx = 0;
    cyc = 0;
    stall = 0;
    prev_hold = 0;
    prev_data = '0;
    got_words.delete();
    while (1) begin
      @(posedge clk); #1;
      ov = out_valid; od = out_data; ir = in_ready;
      if (prev_hold) begin
        chk("hold_valid", {31'd0, ov}, 32'd1);
        chk("hold_data", {21'd0, od}, {21'd0, prev_data});
      end
      if (ov) chk("in_ready_emit", {31'd0, ir}, 32'd0);
      if (idx >= n && !ov) break;
      if (++cyc > 4000) begin
        chk("timeout", 32'd0, 32'd1);
        break;
      end
      case (mode)
        0:       ord = ($urandom_range(0, 2) != 0);
        1:       ord = 1'b1;
        default: ord = (stall >= 3);
      endcase
      out_ready = ord;
      if (idx < n) begin
        in_valid = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data  = s[idx];
        in_last  = use_last && (idx == n - 1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      if (ov && ord) begin
        got_words.push_back(od);
        stall = 0;
      end else if (ov) begin
        stall++;
      end
      if (in_valid && ir) idx++;
      prev_hold = ov && !ord;
      prev_data = od;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_nwords"}, got_words.size(), exp_words.size());
    for (int i = 0; i < got_words.size() && i < exp_words.size(); i++)
      chk({tag, "_word"}, {21'd0, got_words[i]}, {21'd0, exp_words[i]});
    chk({tag, "_wcount"}, {19'd0, word_count}, exp_words.size() % (1 << CNT_W));
    chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_code"}, {30'd0, err_code}, {30'd0, exp_code});
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_od"}, {21'd0, out_data}, 32'd0);
    chk({tag, "_wc"}, {19'd0, word_count}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_code"}, {30'd0, err_code}, 32'd0);
    chk({tag, "_ir"}, {31'd0, in_ready}, 32'd1);
  endtask

  function automatic string gen_stream();
    string s;
    int nl;
    int r;
    int nd;
    s = "";
    nl = $urandom_range(1, 5);
    for (int i = 0; i < nl; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) s = {s, "\n"};
      else if (r == 1) s = {s, "Q7\n"};
      else begin
        s = {s, ($urandom_range(0, 1) != 0) ? "L" : "R"};
        nd = (r == 2) ? 0 : $urandom_range(1, 4);
        for (int k = 0; k < nd; k++)
          s = {s, $sformatf("%c", 8'h30 + 8'($urandom_range(0, 9)))};
        if (r == 3) s = {s, "Z"};
        if (i != nl - 1 || $urandom_range(0, 3) != 0) s = {s, "\n"};
      end
    end
    return s;
  endfunction

  initial begin
    string rs;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_cleared("reset");

    // Two lines, full rate
    model("R26\nL5\n");
    run_stream("R26\nL5\n", 1, 1);
    check_result("basic");
    if (got_words.size() == 2) begin
      chk("basic_w0", {21'd0, got_words[0]}, 32'h01A);
      chk("basic_w1", {21'd0, got_words[1]}, 32'h405);
    end

    // Leading zeros, max magnitude, no trailing newline, 3-cycle stalls
    do_reset();
    model("L0007\nR1023");
    run_stream("L0007\nR1023", 2, 1);
    check_result("stall");

    // Overflow, then input keeps draining
    do_reset();
    model("R1024\n");
    run_stream("R1024\n", 1, 1);
    check_result("ovf");
    chk("ovf_ir", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = B_R;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ovf_drain_ov", {31'd0, out_valid}, 32'd0);
    chk("ovf_drain_code", {30'd0, err_code}, 32'd2);

    do_reset();
    model("R\n");
    run_stream("R\n", 1, 1);
    check_result("trunc");

    do_reset();
    model("X5\n");
    run_stream("X5\n", 1, 1);
    check_result("badch");

    do_reset();
    model("\n\nR3\n");
    run_stream("\n\nR3\n", 0, 1);
    check_result("blank");

    // Reset mid-line discards the partial line
    do_reset();
    run_stream("L12", 1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_cleared("midrst");
    model("R1\n");
    run_stream("R1\n", 1, 1);
    check_result("after_rst");

    // CRLF handling depends on the build
    do_reset();
    run_stream("R4\r\n", 1, 1);
    exp_words.delete();
`ifdef ROT_ENC_CRLF_EN
    exp_words.push_back(11'h004);
    exp_done = 1; exp_err = 0; exp_code = 2'b00;
`else
    exp_done = 0; exp_err = 1; exp_code = 2'b01;
`endif
    check_result("crlf");

    // Random streams
    for (int t = 0; t < 25; t++) begin
      do_reset();
      rs = gen_stream();
      model(rs);
      run_stream(rs, 0, 1);
      check_result("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
